reflet_irq_controller: RTL and testbench

REFLET_IRQ_CONTROLLER -- requirements
Module: reflet_irq_controller

---
 rtl/reflet_irq_controller_if.sv | 22 ++
 rtl/reflet_irq_controller.sv | 140 ++++++++++++++
 tb/tb_reflet_irq_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/reflet_irq_controller_if.sv
// System bus bundle for the Reflet interrupt controller: one peripheral select, address,
// write strobe and data in each direction.
interface reflet_irq_controller_if #(
    parameter int unsigned wordsize       = 16,
    parameter int unsigned base_addr_size = 16
);
    logic                      enable;
    logic [base_addr_size-1:0] addr;
    logic                      write_en;
    logic [wordsize-1:0]       data_in;
    logic [wordsize-1:0]       data_out;

    modport master (
        output enable, addr, write_en, data_in,
        input  data_out
    );

    modport slave (
        input  enable, addr, write_en, data_in,
        output data_out
    );
endinterface

// File: rtl/reflet_irq_controller.sv
// Four-source interrupt controller with mask, pending and in-service registers, strict
// priority nesting (source 0 highest) and an ack/EOI handshake with the CPU.
module reflet_irq_controller #(
    parameter int unsigned              wordsize       = 16,
    parameter int unsigned              base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr     = 16'hFF20
) (
    input  logic                    clk,
    input  logic                    reset,
    reflet_irq_controller_if.slave  bus,
    input  logic [3:0]              irq_in,
    output logic                    irq_out,
    output logic [1:0]              irq_num,
    input  logic                    irq_ack
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] inserv_q, inserv_d;
    logic [3:0] irq_sync_q, irq_prev_q;
    logic       irq_out_q, irq_out_d;
    logic [1:0] irq_num_q, irq_num_d;

    // Address decode, done one bit wider so base_addr near the top of the map cannot wrap.
    logic [base_addr_size:0] offset_full;
    logic [1:0]              offset;
    logic                    sel;
    logic                    wr_mask, wr_pend, wr_eoi;

    assign offset_full = {1'b0, bus.addr} - {1'b0, base_addr};
    assign offset      = offset_full[1:0];
    assign sel         = bus.enable && (bus.addr >= base_addr)
                         && (offset_full[base_addr_size:2] == '0);
    assign wr_mask     = sel && bus.write_en && (offset == 2'd0);
    assign wr_pend     = sel && bus.write_en && (offset == 2'd1);
    assign wr_eoi      = sel && bus.write_en && (offset == 2'd3);

    logic unused_data;
    assign unused_data = ^bus.data_in[wordsize-1:4];

    logic [wordsize-1:0] rdata;
    always_comb begin
        rdata = '0;
        if (sel) begin
            unique case (offset)
                2'd0:    rdata[3:0] = mask_q;
                2'd1:    rdata[3:0] = pending_q;
                2'd2:    rdata[3:0] = inserv_q;
                default: rdata      = '0;
            endcase
        end
    end
    assign bus.data_out = rdata;

    // Isolating the lowest set bit turns priority comparison into a plain magnitude compare.
    logic [3:0] pm, cand_oh, ins_oh, rise;
    logic [1:0] cand_idx;
    logic       eligible;

    assign pm       = pending_q & mask_q;
    assign cand_oh  = pm & (~pm + 4'd1);
    assign ins_oh   = inserv_q & (~inserv_q + 4'd1);
    assign eligible = (pm != 4'd0) && ((inserv_q == 4'd0) || (cand_oh < ins_oh));
    assign rise     = irq_sync_q & ~irq_prev_q;

    always_comb begin
        cand_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pm[i]) cand_idx = 2'(i);
        end
    end

    logic [3:0] ack_bit, w1c, eoi_clr;

    always_comb begin
        state_d   = state_q;
        irq_out_d = irq_out_q;
        irq_num_d = irq_num_q;
        ack_bit   = 4'd0;
        unique case (state_q)
            StIdle: begin
                if (eligible) begin
                    state_d   = StReq;
                    irq_out_d = 1'b1;
                    irq_num_d = cand_idx;
                end
            end
            StReq: begin
                if (irq_ack) begin
                    ack_bit   = 4'b0001 << irq_num_q;
                    state_d   = StIdle;
                    irq_out_d = 1'b0;
                end else if (!pm[irq_num_q]) begin
                    state_d   = StIdle;
                    irq_out_d = 1'b0;
                end
            end
            default: begin
                state_d   = StIdle;
                irq_out_d = 1'b0;
            end
        endcase

        w1c       = wr_pend ? bus.data_in[3:0] : 4'd0;
        eoi_clr   = wr_eoi ? ins_oh : 4'd0;
        mask_d    = wr_mask ? bus.data_in[3:0] : mask_q;
        // A fresh edge wins over a software clear of the same bit.
        pending_d = (pending_q & ~w1c & ~ack_bit) | rise;
        inserv_d  = (inserv_q & ~eoi_clr) | ack_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mask_q     <= 4'd0;
            pending_q  <= 4'd0;
            inserv_q   <= 4'd0;
            irq_sync_q <= 4'd0;
            irq_prev_q <= 4'd0;
            irq_out_q  <= 1'b0;
            irq_num_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            inserv_q   <= inserv_d;
            irq_sync_q <= irq_in;
            irq_prev_q <= irq_sync_q;
            irq_out_q  <= irq_out_d;
            irq_num_q  <= irq_num_d;
        end
    end

    assign irq_out = irq_out_q;
    assign irq_num = irq_num_q;

endmodule

// File: tb/tb_reflet_irq_controller.sv
// Directed bench for reflet_irq_controller: register access, priority nesting, ack/EOI,
// withdraw and reset behaviour with hand-computed expectations.
module tb_reflet_irq_controller;

    localparam logic [15:0] AMask = 16'hFF20;
    localparam logic [15:0] APend = 16'hFF21;
    localparam logic [15:0] AIns  = 16'hFF22;
    localparam logic [15:0] AEoi  = 16'hFF23;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_in = 4'd0;
    logic       irq_out;
    logic [1:0] irq_num;
    logic       irq_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    reflet_irq_controller_if #(.wordsize(16), .base_addr_size(16)) bus_if ();

    reflet_irq_controller dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .irq_in  (irq_in),
        .irq_out (irq_out),
        .irq_num (irq_num),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus_if.enable   = 1'b1;
        bus_if.addr     = a;
        bus_if.data_in  = d;
        bus_if.write_en = 1'b1;
        tick();
        bus_if.write_en = 1'b0;
        bus_if.enable   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic en, input logic [15:0] a,
                          input logic [15:0] exp);
        bus_if.enable   = en;
        bus_if.addr     = a;
        bus_if.write_en = 1'b0;
        #1;
        check(tag, bus_if.data_out, exp);
        bus_if.enable   = 1'b0;
    endtask

    task automatic out_chk(input string tag, input logic exp_out, input logic [1:0] exp_num);
        check({tag, "_out"}, 16'(irq_out), 16'(exp_out));
        if (exp_out) check({tag, "_num"}, 16'(irq_num), 16'(exp_num));
    endtask

    task automatic pulse(input logic [3:0] src);
        irq_in = src;
        tick();
        irq_in = 4'd0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        bus_if.enable   = 1'b0;
        bus_if.addr     = '0;
        bus_if.write_en = 1'b0;
        bus_if.data_in  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd_chk("rst_mask", 1'b1, AMask, 16'h0000);
        rd_chk("rst_pend", 1'b1, APend, 16'h0000);
        rd_chk("rst_ins",  1'b1, AIns,  16'h0000);
        rd_chk("rst_eoi",  1'b1, AEoi,  16'h0000);
        out_chk("rst", 1'b0, 2'd0);

        // Basic request and ack on source 2
        wr(AMask, 16'h000F);
        rd_chk("mask_rw", 1'b1, AMask, 16'h000F);
        pulse(4'b0100);
        rd_chk("s2_pend_early", 1'b1, APend, 16'h0000);
        tick();
        rd_chk("s2_pend", 1'b1, APend, 16'h0004);
        out_chk("s2_pre", 1'b0, 2'd0);
        tick();
        out_chk("s2_req", 1'b1, 2'd2);
        ack();
        rd_chk("s2_ack_pend", 1'b1, APend, 16'h0000);
        rd_chk("s2_ack_ins",  1'b1, AIns,  16'h0004);
        out_chk("s2_ack", 1'b0, 2'd0);

        // Nesting under INSERV[2]: source 3 blocked, source 1 preempts
        irq_in = 4'b1000;
        tick();
        tick();
        tick();
        out_chk("s3_blocked", 1'b0, 2'd0);
        irq_in = 4'b1010;
        tick();
        tick();
        tick();
        out_chk("s1_req", 1'b1, 2'd1);
        irq_in = 4'd0;
        ack();
        rd_chk("nest_ins",  1'b1, AIns,  16'h0006);
        rd_chk("nest_pend", 1'b1, APend, 16'h0008);
        tick();
        out_chk("s3_still_blocked", 1'b0, 2'd0);
        wr(AEoi, 16'h1234);
        rd_chk("eoi1_ins", 1'b1, AIns, 16'h0004);
        wr(AEoi, 16'h0000);
        rd_chk("eoi2_ins", 1'b1, AIns, 16'h0000);
        tick();
        out_chk("s3_req", 1'b1, 2'd3);
        ack();
        rd_chk("s3_ins", 1'b1, AIns, 16'h0008);
        wr(AEoi, 16'h0000);
        wr(AEoi, 16'h0000);
        rd_chk("eoi_empty", 1'b1, AIns, 16'h0000);

        // Masked source becomes requestable once unmasked
        wr(AMask, 16'h0000);
        pulse(4'b0001);
        tick();
        tick();
        rd_chk("m_pend", 1'b1, APend, 16'h0001);
        out_chk("m_masked", 1'b0, 2'd0);
        wr(AMask, 16'h0001);
        tick();
        out_chk("m_req", 1'b1, 2'd0);
        ack();
        wr(AEoi, 16'h0000);
        wr(AMask, 16'h000F);

        // Software withdraw via write-1-to-clear; later ack ignored
        pulse(4'b0010);
        tick();
        tick();
        out_chk("w_req", 1'b1, 2'd1);
        wr(APend, 16'h0002);
        tick();
        out_chk("w_drop", 1'b0, 2'd0);
        rd_chk("w_pend", 1'b1, APend, 16'h0000);
        ack();
        rd_chk("w_ins", 1'b1, AIns, 16'h0000);
        out_chk("w_idle", 1'b0, 2'd0);

        // Edge and write-1-to-clear in the same cycle: bit stays set
        pulse(4'b0100);
        wr(APend, 16'h0004);
        rd_chk("set_wins", 1'b1, APend, 16'h0004);
        tick();
        out_chk("sw_req", 1'b1, 2'd2);
        wr(APend, 16'h0004);
        tick();
        out_chk("sw_drop", 1'b0, 2'd0);

        // EOI and ack together
        pulse(4'b0010);
        tick();
        tick();
        ack();
        pulse(4'b0001);
        tick();
        tick();
        out_chk("ea_req", 1'b1, 2'd0);
        irq_ack = 1'b1;
        wr(AEoi, 16'h0000);
        irq_ack = 1'b0;
        rd_chk("ea_ins",  1'b1, AIns,  16'h0001);
        rd_chk("ea_pend", 1'b1, APend, 16'h0000);
        wr(AEoi, 16'h0000);

        // Reset while requesting
        pulse(4'b0100);
        tick();
        tick();
        out_chk("r_req", 1'b1, 2'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_out", 16'(irq_out), 16'h0000);
        check("r_num", 16'(irq_num), 16'h0000);
        rd_chk("r_mask", 1'b1, AMask, 16'h0000);
        rd_chk("r_pend", 1'b1, APend, 16'h0000);
        rd_chk("r_ins",  1'b1, AIns,  16'h0000);
        ack();
        rd_chk("r_ack_ins", 1'b1, AIns, 16'h0000);

        // Address decode
        wr(AMask, 16'h000F);
        rd_chk("dec_hit",   1'b1, AMask,    16'h000F);
        rd_chk("dec_noen",  1'b0, AMask,    16'h0000);
        rd_chk("dec_below", 1'b1, 16'hFF1F, 16'h0000);
        rd_chk("dec_above", 1'b1, 16'hFF24, 16'h0000);
        wr(16'hFF24, 16'h0000);
        rd_chk("dec_nowr", 1'b1, AMask, 16'h000F);

        // Source held high through reset release
        irq_in = 4'b1000;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        rd_chk("hold_pend0", 1'b1, APend, 16'h0000);
        tick();
        tick();
        rd_chk("hold_pend", 1'b1, APend, 16'h0008);
        irq_in = 4'd0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
